// File: rtl/div_pkg.sv
// Shared definitions for the clock-divider scheduler: FSM state encoding and
// the smallest divide ratio that still produces a toggling output.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int DIV_MIN = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a one-hot grant. The pointer remembers
// which requester won last and only moves when the owner commits a grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (update) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/clkdiv_sched.sv
// Programmable clock divider whose ratio can be changed by two requesters;
// a change is applied only at a period boundary so no short period is emitted.
module clkdiv_sched
    import div_pkg::*;
#(
    parameter int W       = 8,
    parameter int DIV_RST = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [W-1:0] div0,
    input  logic [W-1:0] div1,
    output logic [1:0]   ack,
    output logic         err,
    output logic         busy,
    output logic         o_clk,
    output logic         tick,
    output logic [W-1:0] div_cur
);

    localparam logic [W-1:0] DIV_RST_W = W'(DIV_RST);
    localparam logic [W-1:0] DIV_MIN_W = W'(DIV_MIN);

    generate
        if (DIV_RST < DIV_MIN || DIV_RST > (1 << W) - 1) begin : g_bad_div_rst
            $error("clkdiv_sched: DIV_RST=%0d outside %0d..2^W-1", DIV_RST, DIV_MIN);
        end
    endgenerate

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] cnt;
    logic [W-1:0] div_nxt;
    logic [1:0]   grant;
    logic [1:0]   gnt_q;
    logic         reject_q;
    logic [W-1:0] sel_div;
    logic         at_wrap;
    logic         take;

    assign at_wrap = (cnt == div_cur - W'(1));
    assign take    = (state_q == ST_IDLE) && (|req);
    assign sel_div = grant[1] ? div1 : div0;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .update (take),
        .gnt    (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A ratio below DIV_MIN skips WAIT entirely so the running waveform is untouched.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = (sel_div < DIV_MIN_W) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (at_wrap) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack  = 2'b00;
        err  = 1'b0;
        busy = (state_q != ST_IDLE);
        if (state_q == ST_ACK) begin
            ack = gnt_q;
            err = reject_q;
        end
    end

    // The counter wraps at the end of every period; the ratio swap rides on that same wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            div_cur  <= DIV_RST_W;
            div_nxt  <= DIV_RST_W;
            o_clk    <= 1'b0;
            tick     <= 1'b0;
            gnt_q    <= 2'b00;
            reject_q <= 1'b0;
        end else begin
            o_clk <= (cnt < (div_cur >> 1));
            tick  <= (cnt == '0);
            if (at_wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
            if (state_q == ST_WAIT && at_wrap) begin
                div_cur <= div_nxt;
            end
            if (take) begin
                div_nxt  <= sel_div;
                gnt_q    <= grant;
                reject_q <= (sel_div < DIV_MIN_W);
            end
        end
    end

endmodule
